writeback_arbiter: RTL and testbench

Multi-source register-file writeback stage that generalises the single-result writeback path. It accepts results from NUM_SRC execution units (ALU, load unit, multiplier, ...) over independent valid/ready channels and buffers each one in a small per-source FIFO. Each cycle it selects one buffered result round-robin and drives the single register-file write port. It sits between the execute units and the register file; writes to x0 are discarded at acceptance.

---
 rtl/riscat_pkg.sv | 15 +
 rtl/wb_fifo.sv | 61 ++++++
 rtl/writeback_arbiter.sv | 124 ++++++++++++
 tb/tb_writeback_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscat_pkg.sv
// riscat_pkg: shared constants and types for the register-file writeback path.
//   XLEN       - register data width
//   REG_ADDR_W - register address width
//   wb_entry_t - one buffered writeback result {addr, data}
package riscat_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small per-source result buffer for the writeback arbiter.
//   clk, reset_n - clock, asynchronous active-low reset
//   push, din    - write din when push && !full
//   pop, dout    - dout is the head, readable combinationally; pop drops it
//   count        - number of stored entries (0..DEPTH)
//   full, empty  - status derived from count
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module wb_fifo
  import riscat_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                din,
  output wb_entry_t                dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      // Simultaneous push and pop leaves the count unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: collects results from NUM_SRC execution units, buffers
// each source in a wb_fifo and drives the single register-file write port,
// choosing one buffered result per cycle in round-robin order.
//   clk, reset_n            - clock, asynchronous active-low reset
//   src_valid/src_ready     - per-source handshake (NUM_SRC bits each)
//   src_addr, src_data      - per-source destination and result, packed
//                             source 0 in the low slice
//   rd_wr_en                - register-file write strobe, one cycle per write
//   reg_wr_addr/reg_wr_data - write address and data (hold when idle)
//   wr_src                  - index of the source being written
//   busy                    - any FIFO non-empty or a write in flight
//
// Handshake: a transfer on source i happens at a rising edge where
// src_valid[i] && src_ready[i]. src_ready[i] depends only on the registered
// FIFO count (not full), never on src_valid or on arbitration. A transfer to
// register x0 completes the handshake but is not buffered.
//
// XLEN and REG_ADDR_W must match riscat_pkg, which fixes the entry layout.
module writeback_arbiter
  import riscat_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int XLEN       = riscat_pkg::XLEN,
  parameter int REG_ADDR_W = riscat_pkg::REG_ADDR_W,
  parameter int FIFO_DEPTH = 2,
  localparam int SW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC*XLEN-1:0]       src_data,
  output logic                          rd_wr_en,
  output logic [REG_ADDR_W-1:0]         reg_wr_addr,
  output logic [XLEN-1:0]               reg_wr_data,
  output logic [SW-1:0]                 wr_src,
  output logic                          busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t            head       [NUM_SRC];
  logic [CW-1:0]        fifo_count [NUM_SRC];
  logic [NUM_SRC-1:0]   fifo_full;
  logic [NUM_SRC-1:0]   fifo_empty;
  logic [NUM_SRC-1:0]   push;
  logic [NUM_SRC-1:0]   pop;

  logic [SW-1:0]        last_grant;
  logic [SW-1:0]        cand;
  logic [SW-1:0]        grant_idx;
  logic                 grant_valid;
  wb_entry_t            grant_entry;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    wb_entry_t din;

    assign din.addr     = src_addr[g*REG_ADDR_W +: REG_ADDR_W];
    assign din.data     = src_data[g*XLEN +: XLEN];
    assign src_ready[g] = !fifo_full[g];
    // x0 writes are swallowed here: accepted but never buffered.
    assign push[g]      = src_valid[g] && src_ready[g] && (din.addr != '0);
    assign pop[g]       = grant_valid && (grant_idx == SW'(g));

    wb_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push[g]),
      .pop     (pop[g]),
      .din     (din),
      .dout    (head[g]),
      .count   (fifo_count[g]),
      .full    (fifo_full[g]),
      .empty   (fifo_empty[g])
    );
  end

  // Round-robin search over non-empty heads, starting just after the last
  // source that was granted. The first hit in that rotated order wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = SW'((int'(last_grant) + k) % NUM_SRC);
      if (!grant_valid && !fifo_empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_entry = head[grant_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_wr_en    <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      wr_src      <= '0;
      // Start at the last index so source 0 wins the first arbitration.
      last_grant  <= SW'(NUM_SRC - 1);
    end else begin
      rd_wr_en <= grant_valid;
      if (grant_valid) begin
        reg_wr_addr <= grant_entry.addr;
        reg_wr_data <= grant_entry.data;
        wr_src      <= grant_idx;
        last_grant  <= grant_idx;
      end
    end
  end

  always_comb begin
    busy = rd_wr_en;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (fifo_count[i] != '0) busy = 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed vector table plus hand-written multi-cycle
// sequences and a random-valid run, all checked by a per-source scoreboard.
module tb_writeback_arbiter;

  localparam int NS = 4;
  localparam int XW = 32;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset_n;
  logic [NS-1:0]     src_valid;
  logic [NS-1:0]     src_ready;
  logic [NS*AW-1:0]  src_addr;
  logic [NS*XW-1:0]  src_data;
  logic              rd_wr_en;
  logic [AW-1:0]     reg_wr_addr;
  logic [XW-1:0]     reg_wr_data;
  logic [1:0]        wr_src;
  logic              busy;

  always #5 clk = ~clk;

  writeback_arbiter #(
    .NUM_SRC    (NS),
    .XLEN       (XW),
    .REG_ADDR_W (AW),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_addr    (src_addr),
    .src_data    (src_data),
    .rd_wr_en    (rd_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .wr_src      (wr_src),
    .busy        (busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [AW+XW-1:0]   exp_q [NS][$];
  int                 wait_cnt [NS];
  logic [AW+XW+1:0]   wlog [$];
  int                 wcyc [$];
  logic [AW+XW-1:0]   exp_e;

  task automatic clear_sb();
    for (int i = 0; i < NS; i++) begin
      exp_q[i].delete();
      wait_cnt[i] = 0;
    end
  endtask

  // Accepted non-x0 transfers, sampled with pre-edge values.
  always @(posedge clk) begin
    cyc++;
    if (reset_n) begin
      for (int i = 0; i < NS; i++) begin
        if (src_valid[i] && src_ready[i] && src_addr[i*AW +: AW] != '0)
          exp_q[i].push_back({src_addr[i*AW +: AW], src_data[i*XW +: XW]});
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_wr_en) begin
        wlog.push_back({wr_src, reg_wr_addr, reg_wr_data});
        wcyc.push_back(cyc);
        if (exp_q[wr_src].size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: write src %0d addr %0d data %h, required none outstanding",
                   wr_src, reg_wr_addr, reg_wr_data);
        end else begin
          exp_e = exp_q[wr_src].pop_front();
          check("sb_write", {27'b0, reg_wr_addr, reg_wr_data}, {27'b0, exp_e});
          check("sb_starve", 64'(wait_cnt[wr_src] <= NS), 64'd1);
          wait_cnt[wr_src] = 0;
        end
      end
      for (int i = 0; i < NS; i++) begin
        if (exp_q[i].size() != 0 && !(rd_wr_en && wr_src == 2'(i))) wait_cnt[i]++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_src(input int i, input logic v, input logic [AW-1:0] a, input logic [XW-1:0] d);
    src_valid[i]         = v;
    src_addr[i*AW +: AW] = a;
    src_data[i*XW +: XW] = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NS; i++) set_src(i, 1'b0, '0, '0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(busy), 64'd0);
    for (int i = 0; i < NS; i++) check("drain_queue", 64'(exp_q[i].size()), 64'd0);
  endtask

  // Sources 0 and 1 stream n0/n1 items; an item advances only when ready,
  // which is stable at the negedge because it comes from registered state.
  task automatic stream(input int n0, input int n1, output bit saw1_low);
    int k0 = 0;
    int k1 = 0;
    int guard = 0;
    saw1_low = 1'b0;
    while ((k0 < n0 || k1 < n1) && guard < 200) begin
      @(negedge clk);
      guard++;
      if (k0 < n0) begin
        set_src(0, 1'b1, AW'(1 + (k0 % 15)), 32'hA000_0000 + k0);
        if (src_ready[0]) k0++;
      end else set_src(0, 1'b0, '0, '0);
      if (k1 < n1) begin
        set_src(1, 1'b1, AW'(16 + (k1 % 15)), 32'hB000_0000 + k1);
        if (src_ready[1]) k1++;
        else saw1_low = 1'b1;
      end else set_src(1, 1'b0, '0, '0);
    end
    check("stream_guard", 64'(guard < 200), 64'd1);
    @(negedge clk);
    clear_all();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int              src;
    logic [AW-1:0]   addr;
    logic [XW-1:0]   data;
    logic            exp_wr;
  } vec_t;

  vec_t vecs [6];
  bit   took [NS];
  bit   saw_low;
  int   n1;

  initial begin
    vecs[0] = '{src: 0, addr: 5'd5,  data: 32'hDEAD_BEEF, exp_wr: 1'b1};
    vecs[1] = '{src: 1, addr: 5'd31, data: 32'hFFFF_FFFF, exp_wr: 1'b1};
    vecs[2] = '{src: 3, addr: 5'd1,  data: 32'h0000_0000, exp_wr: 1'b1};
    vecs[3] = '{src: 2, addr: 5'd0,  data: 32'h0000_1234, exp_wr: 1'b0};
    vecs[4] = '{src: 2, addr: 5'd17, data: 32'hA5A5_5A5A, exp_wr: 1'b1};
    vecs[5] = '{src: 3, addr: 5'd0,  data: 32'hFFFF_FFFF, exp_wr: 1'b0};

    reset_n   = 1'b0;
    src_valid = '0;
    src_addr  = '0;
    src_data  = '0;
    clear_sb();
    repeat (3) @(negedge clk);

    check("rst_wr_en", 64'(rd_wr_en), 64'd0);
    check("rst_addr", 64'(reg_wr_addr), 64'd0);
    check("rst_data", 64'(reg_wr_data), 64'd0);
    check("rst_src", 64'(wr_src), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(src_ready), 64'hF);
    reset_n = 1'b1;
    @(negedge clk);

    // Single transfers: write appears in the cycle after edge E+1, then stops.
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      set_src(vecs[v].src, 1'b1, vecs[v].addr, vecs[v].data);
      check("vec_ready", 64'(src_ready[vecs[v].src]), 64'd1);
      @(negedge clk);
      set_src(vecs[v].src, 1'b0, '0, '0);
      check("vec_busy", 64'(busy), 64'(vecs[v].exp_wr));
      @(negedge clk);
      check("vec_wr_en", 64'(rd_wr_en), 64'(vecs[v].exp_wr));
      if (vecs[v].exp_wr) begin
        check("vec_addr", 64'(reg_wr_addr), 64'(vecs[v].addr));
        check("vec_data", 64'(reg_wr_data), 64'(vecs[v].data));
        check("vec_src", 64'(wr_src), 64'(vecs[v].src));
      end
      @(negedge clk);
      check("vec_wr_en_after", 64'(rd_wr_en), 64'd0);
    end

    // x0 drop: two back-to-back transfers, only the second is written.
    wlog.delete();
    wcyc.delete();
    @(negedge clk);
    set_src(0, 1'b1, 5'd0, 32'h0000_1234);
    check("x0_ready_a", 64'(src_ready[0]), 64'd1);
    @(negedge clk);
    set_src(0, 1'b1, 5'd3, 32'h0000_0055);
    check("x0_ready_b", 64'(src_ready[0]), 64'd1);
    @(negedge clk);
    clear_all();
    repeat (4) @(negedge clk);
    check("x0_write_count", 64'(wlog.size()), 64'd1);
    if (wlog.size() == 1) check("x0_write", 64'(wlog[0]), {25'b0, 2'd0, 5'd3, 32'h0000_0055});

    // Contention: writes alternate between the two sources, one per cycle.
    wlog.delete();
    wcyc.delete();
    stream(4, 4, saw_low);
    wait_idle("cont_idle");
    check("cont_count", 64'(wlog.size()), 64'd8);
    for (int k = 1; k < wlog.size(); k++) begin
      check("cont_alternate", 64'(wlog[k][AW+XW +: 2] != wlog[k-1][AW+XW +: 2]), 64'd1);
      check("cont_back_to_back", 64'(wcyc[k] - wcyc[k-1]), 64'd1);
    end

    // Backpressure: src 1 stalls on a full FIFO but loses nothing.
    wlog.delete();
    wcyc.delete();
    stream(12, 6, saw_low);
    wait_idle("bp_idle");
    check("bp_ready_dropped", 64'(saw_low), 64'd1);
    n1 = 0;
    for (int k = 0; k < wlog.size(); k++) begin
      if (wlog[k][AW+XW +: 2] == 2'd1) begin
        check("bp_src1_order", 64'(wlog[k][XW-1:0]), 64'(32'hB000_0000 + n1));
        n1++;
      end
    end
    check("bp_src1_count", 64'(n1), 64'd6);

    // Reset mid-stream with every source pushing so the FIFOs fill up.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) set_src(i, 1'b1, AW'(4 + i), 32'hC000_0000 + c);
    end
    @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    check("mid_full", 64'(src_ready[1:0]), 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_wr_en", 64'(rd_wr_en), 64'd0);
    check("arst_addr", 64'(reg_wr_addr), 64'd0);
    check("arst_data", 64'(reg_wr_data), 64'd0);
    check("arst_src", 64'(wr_src), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ready", 64'(src_ready), 64'hF);
    clear_all();
    clear_sb();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_no_write", 64'(rd_wr_en), 64'd0);
      check("post_rst_busy", 64'(busy), 64'd0);
      check("post_rst_ready", 64'(src_ready), 64'hF);
    end

    // After reset source 0 wins the first arbitration.
    set_src(0, 1'b1, 5'd9, 32'h0000_0900);
    set_src(1, 1'b1, 5'd10, 32'h0000_0A00);
    @(negedge clk);
    clear_all();
    @(negedge clk);
    check("first_win_en", 64'(rd_wr_en), 64'd1);
    check("first_win_src", 64'(wr_src), 64'd0);
    @(negedge clk);
    check("second_win_src", 64'(wr_src), 64'd1);
    check("second_win_addr", 64'(reg_wr_addr), 64'd10);
    wait_idle("rr_idle");

    // Random valid patterns on all sources; the scoreboard checks order,
    // completeness and starvation.
    for (int i = 0; i < NS; i++) took[i] = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (!src_valid[i] || took[i]) begin
          if ($urandom_range(0, 99) < 60)
            set_src(i, 1'b1, AW'($urandom_range(0, 31)), $urandom());
          else
            set_src(i, 1'b0, '0, '0);
        end
        took[i] = src_valid[i] && src_ready[i];
      end
    end
    @(negedge clk);
    clear_all();
    wait_idle("rand_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
